mmio_sim_monitor: RTL
=====================

// Module: mmio_sim_monitor
// PURPOSE
//  Synthesizable memory-mapped monitor for the CPU MMIO bus: halt register, NCH byte-console
//  channels (each buffered by a DEPTH-entry FIFO with ready/valid drain), and a free-running
//  cycle counter with a programmable abort limit. Sits beside dmem on the MMIO decode; the sim
//  top and the board top (UART drain) both consume its outputs.
// PARAMETERS
//  BASE   32'hf0000000  MMIO window base; block decodes BASE+0x000..BASE+0x2ff
//  NCH    2             console channel count, 1..8
//  DEPTH  16            FIFO entries per channel, power of two, >=2
//  CW     64            cycle counter width, 33..64
// PORTS
//  clk         in   1        system clock
//  rstn        in   1        asynchronous active-low reset
//  mmio_oe     in   1        MMIO access strobe, one cycle per access
//  mmio_we     in   4        byte write enables; write iff mmio_we[0], else read
//  mmio_addr   in   32       byte address
//  mmio_wdata  in   32       write data
//  mmio_rdata  out  32       read data, registered
//  max_cycle   in   CW       abort limit; 0 disables
//  halted      out  1        sticky, set by HALT write
//  halt_code   out  32       wdata of the HALT write
//  abort       out  1        sticky, cycle > max_cycle
//  tx_valid    out  NCH      per-channel FIFO non-empty
//  tx_ready    in   NCH      per-channel consumer accept
//  tx_data     out  NCH*8    per-channel head byte, channel c at [8c+:8]
// BEHAVIOUR
//  Reset (rstn=0, async): halted=0, halt_code=0, abort=0, cycle=0, all FIFOs empty,
//   tx_valid=0, tx_data=0, overflow flags=0, mmio_rdata=0.
//  Map (offset from BASE):
//   0x000        HALT   W: halted<=1, halt_code<=wdata. R: {31'b0,halted}
//   0x100+16c    TXD[c] W: push wdata[7:0]. R: {31'b0,!full} (nonzero = TX available)
//   0x104+16c    TXS[c] R: {count[15:0],15'b0,ovf}. W: any write clears ovf
//   0x200/0x204  CYC    R: cycle[31:0] / zero-extended cycle[CW-1:32]. W: ignored
//   Unmapped or c>=NCH: reads return 0, writes ignored.
//  Access: write takes effect on the clk edge with mmio_oe&&mmio_we[0]. Read: mmio_rdata valid
//   exactly 1 cycle after the mmio_oe edge and holds until the next read. Non-read cycles hold.
//  FIFO: push when write && !full; write to full FIFO drops the byte, sets ovf (sticky).
//   Pop on tx_valid&&tx_ready. Push and pop in the same cycle: both happen, count unchanged,
//   including when full (push accepted, no ovf). Pointers wrap mod DEPTH; count 0..DEPTH.
//   tx_data = head entry, stable while tx_valid&&!tx_ready.
//  Cycle: cycle increments every clk while !halted&&!abort; saturates at all-ones.
//   abort<=1 on the edge where max_cycle!=0 && cycle>max_cycle.
//  After halted or abort: FIFO pushes and HALT writes ignored (halt_code frozen); reads,
//   TXS ovf clears and FIFO drain continue.
//  HALT write and abort condition in the same cycle: both flags set.
//  Only reset clears halted/abort; reset mid-drain discards FIFO contents.
// TESTING
//  1 Reset release, write 0x48 then 0x69 to BASE+0x100, tx_ready[0]=1 -> tx_data[0]=0x48 then 0x69,
//    tx_valid[0] low after 2 pops.
//  2 tx_ready=0, DEPTH+1 writes to TXD[1] -> TXD[1] read=0 after DEPTH, TXS[1] = {DEPTH,ovf=1};
//    write TXS[1] -> ovf=0.
//  3 Full FIFO, push with tx_ready=1 same cycle -> count stays DEPTH, ovf=0, new byte last out.
//  4 Write 0xDEADBEEF to BASE+0x000 -> halted=1, halt_code=0xDEADBEEF, CYC read constant, later
//    TXD writes not queued.
//  5 max_cycle=100 -> abort rises on the edge where cycle=101; max_cycle=0 -> abort never.
//  6 Assert rstn=0 mid-drain with 5 bytes queued -> tx_valid=0 immediately (async), flags 0.

Source files
------------

// File: rtl/mmio_sim_monitor.sv
// mmio_sim_monitor
//   MMIO-mapped simulation/board monitor. Provides a sticky halt register with
//   a halt code, NCH byte-console channels (each a DEPTH-entry FIFO drained
//   over ready/valid), and a free-running cycle counter with an abort limit.
//
// Ports
//   clk, rstn                 system clock, asynchronous active-low reset
//   mmio_oe                   access strobe (one cycle per access)
//   mmio_we[3:0]              write iff mmio_we[0], otherwise the access is a read
//   mmio_addr, mmio_wdata     byte address and write data
//   mmio_rdata                registered read data, updated only by reads
//   max_cycle                 abort limit, 0 disables
//   halted, halt_code         sticky halt flag and the data written to HALT
//   abort                     sticky, set once the cycle count passes max_cycle
//   tx_valid/tx_ready/tx_data per-channel FIFO drain, channel c at tx_data[8c+:8]
//
// Map (offset from BASE)
//   0x000 HALT, 0x100+16c TXD[c], 0x104+16c TXS[c], 0x200/0x204 CYC lo/hi
module mmio_sim_monitor #(
  parameter logic [31:0] BASE  = 32'hf0000000,
  parameter int          NCH   = 2,
  parameter int          DEPTH = 16,
  parameter int          CW    = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mmio_oe,
  input  logic [3:0]       mmio_we,
  input  logic [31:0]      mmio_addr,
  input  logic [31:0]      mmio_wdata,
  output logic [31:0]      mmio_rdata,
  input  logic [CW-1:0]    max_cycle,
  output logic             halted,
  output logic [31:0]      halt_code,
  output logic             abort,
  output logic [NCH-1:0]   tx_valid,
  input  logic [NCH-1:0]   tx_ready,
  output logic [NCH*8-1:0] tx_data
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [31:0]     off_s;
  logic [3:0]      ch_s;
  logic            wr_s, rd_s, stop_s, ch_ok_s;
  logic            is_halt_s, is_txd_s, is_txs_s, is_cyc_lo_s, is_cyc_hi_s;
  logic [CW-1:0]   cycle_r;
  logic            abort_set_s;
  logic [NCH-1:0]  full_s, ovf_s;
  logic [CNTW-1:0] cnt_s [NCH];
  logic            sel_full_s, sel_ovf_s;
  logic [CNTW-1:0] sel_cnt_s;
  logic [31:0]     rd_val_s;
  logic            unused_s;

  assign unused_s = ^mmio_we[3:1];

  // Address decode relative to the window base.
  assign off_s       = mmio_addr - BASE;
  assign ch_s        = off_s[7:4];
  assign ch_ok_s     = (32'(ch_s) < 32'(NCH));
  assign wr_s        = mmio_oe && mmio_we[0];
  assign rd_s        = mmio_oe && !mmio_we[0];
  assign stop_s      = halted || abort;
  assign is_halt_s   = (off_s == 32'h0000_0000);
  assign is_txd_s    = (off_s[31:8] == 24'h000001) && (off_s[3:0] == 4'h0) && ch_ok_s;
  assign is_txs_s    = (off_s[31:8] == 24'h000001) && (off_s[3:0] == 4'h4) && ch_ok_s;
  assign is_cyc_lo_s = (off_s == 32'h0000_0200);
  assign is_cyc_hi_s = (off_s == 32'h0000_0204);
  assign abort_set_s = (max_cycle != {CW{1'b0}}) && (cycle_r > max_cycle);

  // Per-channel FIFOs. The head byte is registered from the next-state
  // pointers so tx_data is a flop output and is zero at reset.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [7:0]      mem_r [DEPTH];
    logic [PW-1:0]   rd_ptr_r, wr_ptr_r, rd_nxt_s;
    logic [CNTW-1:0] count_r, count_nxt_s;
    logic            sel_s, push_req_s, push_s, pop_s, valid_r, ovf_r;
    logic [7:0]      head_r, head_nxt_s;

    assign sel_s      = (ch_s == 4'(c));
    assign full_s[c]  = (count_r == FULL_CNT);
    assign pop_s      = valid_r && tx_ready[c];
    assign push_req_s = wr_s && is_txd_s && sel_s && !stop_s;
    // A full FIFO still accepts a push when it pops in the same cycle.
    assign push_s     = push_req_s && (!full_s[c] || pop_s);
    assign rd_nxt_s   = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
    assign cnt_s[c]   = count_r;
    assign ovf_s[c]   = ovf_r;
    assign tx_valid[c]       = valid_r;
    assign tx_data[8*c +: 8] = head_r;

    // Occupancy after this cycle's push/pop.
    always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNTW'(1);
        2'b01:   count_nxt_s = count_r - CNTW'(1);
        default: count_nxt_s = count_r;
      endcase
    end

    // Next head: the incoming byte when it lands in the head slot, else memory.
    always_comb begin
      head_nxt_s = 8'h00;
      if (count_nxt_s == {CNTW{1'b0}}) begin
        head_nxt_s = 8'h00;
      end else if (push_s && (rd_nxt_s == wr_ptr_r)) begin
        head_nxt_s = mmio_wdata[7:0];
      end else begin
        head_nxt_s = mem_r[rd_nxt_s];
      end
    end

    // FIFO storage; contents are only observed through the head register.
    always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= mmio_wdata[7:0];
    end

    // FIFO control state and sticky overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rd_ptr_r <= {PW{1'b0}};
        wr_ptr_r <= {PW{1'b0}};
        count_r  <= {CNTW{1'b0}};
        valid_r  <= 1'b0;
        head_r   <= 8'h00;
        ovf_r    <= 1'b0;
      end else begin
        rd_ptr_r <= rd_nxt_s;
        if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
        count_r  <= count_nxt_s;
        valid_r  <= (count_nxt_s != {CNTW{1'b0}});
        head_r   <= head_nxt_s;
        if (push_req_s && !push_s) ovf_r <= 1'b1;
        else if (wr_s && is_txs_s && sel_s) ovf_r <= 1'b0;
      end
    end
  end

  // Select the addressed channel's status by OR-ing masked per-channel values.
  always_comb begin
    sel_full_s = 1'b0;
    sel_ovf_s  = 1'b0;
    sel_cnt_s  = {CNTW{1'b0}};
    for (int c = 0; c < NCH; c++) begin
      sel_full_s = sel_full_s | (full_s[c] & (ch_s == 4'(c)));
      sel_ovf_s  = sel_ovf_s  | (ovf_s[c]  & (ch_s == 4'(c)));
      sel_cnt_s  = sel_cnt_s  | (cnt_s[c]  & {CNTW{ch_s == 4'(c)}});
    end
  end

  // Read data mux; unmapped offsets and absent channels read as zero.
  always_comb begin
    rd_val_s = 32'h0000_0000;
    if (is_halt_s) begin
      rd_val_s = {31'h0, halted};
    end else if (is_txd_s) begin
      rd_val_s = {31'h0, ~sel_full_s};
    end else if (is_txs_s) begin
      rd_val_s = {16'(sel_cnt_s), 15'h0, sel_ovf_s};
    end else if (is_cyc_lo_s) begin
      rd_val_s = cycle_r[31:0];
    end else if (is_cyc_hi_s) begin
      rd_val_s = 32'(cycle_r[CW-1:32]);
    end else begin
      rd_val_s = 32'h0000_0000;
    end
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) mmio_rdata <= 32'h0000_0000;
    else if (rd_s) mmio_rdata <= rd_val_s;
  end

  // Halt register; frozen once halted or aborted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      halted    <= 1'b0;
      halt_code <= 32'h0000_0000;
    end else if (wr_s && is_halt_s && !stop_s) begin
      halted    <= 1'b1;
      halt_code <= mmio_wdata;
    end
  end

  // Saturating cycle counter and sticky abort.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_r <= {CW{1'b0}};
      abort   <= 1'b0;
    end else begin
      if (abort_set_s) abort <= 1'b1;
      if (!stop_s && (cycle_r != {CW{1'b1}})) cycle_r <= cycle_r + CW'(1);
    end
  end

endmodule
